// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end sharing one GCD engine between two requesters.
// Build option GCD_ARB_ZERO_BYPASS_EN answers pairs with a zero operand without the engine.
module gcd_arbiter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic [1:0]   rsp_valid,
   input  logic [1:0]   rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic [W-1:0] gcd_operand_a,
   output logic [W-1:0] gcd_operand_b,
   output logic         gcd_start,
   input  logic         gcd_result_rdy,
   input  logic [W-1:0] gcd_result_data,
   output logic         gcd_result_taken,
   output logic         busy,
   output logic         grant_id
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_e;

   state_e       state_q, state_d;
   logic         rr_ptr_q, rr_ptr_d;
   logic         grant_q, grant_d;
   logic [W-1:0] op_a_q, op_a_d;
   logic [W-1:0] op_b_q, op_b_d;
   logic [W-1:0] res_q, res_d;

   logic         win;
   logic [W-1:0] win_a, win_b;
   logic         zero_pair;

   always_comb begin
      unique case (req_valid)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         default: win = rr_ptr_q;
      endcase
   end

   assign win_a = win ? req1_a : req0_a;
   assign win_b = win ? req1_b : req0_b;

`ifdef GCD_ARB_ZERO_BYPASS_EN
   assign zero_pair = (win_a == '0) || (win_b == '0);
`else
   assign zero_pair = 1'b0;
`endif

   always_comb begin
      state_d          = state_q;
      rr_ptr_d         = rr_ptr_q;
      grant_d          = grant_q;
      op_a_d           = op_a_q;
      op_b_d           = op_b_q;
      res_d            = res_q;
      req_ready        = 2'b00;
      rsp_valid        = 2'b00;
      gcd_start        = 1'b0;
      gcd_result_taken = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid != 2'b00) begin
               req_ready[win] = 1'b1;
               grant_d        = win;
               op_a_d         = win_a;
               op_b_d         = win_b;
               if (zero_pair) begin
                  // gcd(x,0) == x, and a|b yields x whichever side is 0
                  res_d   = win_a | win_b;
                  state_d = S_RESP;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            gcd_start = 1'b1;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            if (gcd_result_rdy) begin
               gcd_result_taken = 1'b1;
               res_d            = gcd_result_data;
               state_d          = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid[grant_q] = 1'b1;
            if (rsp_ready[grant_q]) begin
               rr_ptr_d = ~grant_q;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // a pending reset suppresses every strobe so an abort leaks nothing
      if (!reset) begin
         req_ready        = 2'b00;
         rsp_valid        = 2'b00;
         gcd_start        = 1'b0;
         gcd_result_taken = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= 1'b0;
         grant_q  <= 1'b0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         res_q    <= res_d;
      end
   end

   assign rsp_data      = reset ? res_q : '0;
   assign gcd_operand_a = reset ? op_a_q : '0;
   assign gcd_operand_b = reset ? op_b_q : '0;
   assign busy          = reset && (state_q != S_IDLE);
   assign grant_id      = reset && grant_q;

endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 SHALL have parameter: W, 16, operand/result width in bits.
REQ-002 SHALL have port: clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-low reset (0 sampled at a clk edge resets the block).
REQ-004 SHALL have ports: req_valid / req_ready  in / out  2 / 2  per-requester operand handshake, bit i = requester i.
REQ-005 SHALL have ports: req0_a, req0_b, req1_a, req1_b  in  W  operand pairs of requesters 0 and 1.
REQ-006 SHALL have ports: rsp_valid / rsp_ready  out / in  2 / 2  per-requester result handshake.
REQ-007 SHALL have port: rsp_data  out  W  GCD result, valid for the requester whose rsp_valid bit is high.
REQ-008 SHALL have ports: gcd_operand_a, gcd_operand_b  out  W  operands to the shared GCD engine.
REQ-009 SHALL have port: gcd_start  out  1  one-cycle pulse launching the engine.
REQ-010 SHALL have ports: gcd_result_rdy / gcd_result_data  in  1 / W  engine result strobe and value.
REQ-011 SHALL have port: gcd_result_taken  out  1  result acknowledge to the engine.
REQ-012 SHALL have ports: busy / grant_id  out  1 / 1  high when state != IDLE / index of the current owner.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-014 IDLE: at most one req_ready bit SHALL be high, combinationally, for the winner; none when req_valid == 0.
REQ-015 Winner SHALL be the single valid requester, or rr_ptr when both are valid.
REQ-016 On accept (req_valid[g] & req_ready[g]) the block SHALL latch operands and g, then go to ISSUE.
REQ-017 ISSUE SHALL last exactly one cycle with gcd_start = 1, then go to WAIT.
REQ-018 gcd_operand_a/b SHALL carry the latched operands from ISSUE through WAIT and be stable.
REQ-019 WAIT: when gcd_result_rdy = 1, gcd_result_taken SHALL be 1 in the same cycle, gcd_result_data latched, next state RESP.
REQ-020 gcd_result_rdy outside WAIT SHALL be ignored, with no gcd_result_taken.
REQ-021 RESP: rsp_valid[g] SHALL be 1, the other bit 0, and rsp_data held until rsp_ready[g] = 1.
REQ-022 On that rsp handshake: rr_ptr <= ~g, next state IDLE.
REQ-023 No new request SHALL be accepted before IDLE is re-entered.
REQ-024 Minimum latency SHALL be: accept edge T; gcd_start in cycle T+1; rsp_valid at T+3 when the engine answers at T+2.
REQ-025 Request operands SHALL not need to stay stable after accept.

Reset
REQ-026 With reset = 0 at a clk edge: state IDLE, rr_ptr = 0, grant_id = 0.
REQ-027 Under reset, the following SHALL be 0: rsp_valid, rsp_data, gcd_start, gcd_result_taken, gcd_operand_a/b, busy.
REQ-028 Reset in any state, including mid-WAIT, SHALL abort the transaction without delivering a response or gcd_result_taken.
REQ-029 Engine recovery after an abort SHALL rely on the engine sharing the same reset.

Configuration
REQ-030 Macro GCD_ARB_ZERO_BYPASS_EN defined: an accepted pair with an operand of 0 SHALL go IDLE -> RESP with rsp_data = a | b, no gcd_start, rsp_valid at T+1.
REQ-031 Macro GCD_ARB_ZERO_BYPASS_EN undefined: every accepted pair SHALL go through ISSUE/WAIT.

Verification
REQ-032 Reset scenario: hold reset = 0 for 2 cycles during WAIT -> all outputs 0, busy = 0, next grant goes to requester 0.
REQ-033 Single request: req0 = (0x010E, 0x00C0), engine model returns 0x0006 after 20 cycles -> one gcd_start pulse with those operands, gcd_result_taken 1 cycle, rsp_valid = 2'b01, rsp_data = 0x0006.
REQ-034 Simultaneous requests after reset: req0 = (270, 192), req1 = (48, 36) -> req0 served first (6), then req1 (0x000C), single accept each, no overlap.
REQ-035 Round-robin: both requesters permanently valid for 4 transactions -> grant_id sequence 0, 1, 0, 1.
REQ-036 Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid/rsp_data stable, req_ready = 0, gcd_start = 0.
REQ-037 Zero operand: req1 = (0x0000, 0x0015) -> with macro rsp_valid = 2'b10, rsp_data = 0x0015 at T+1, no gcd_start; without macro a gcd_start is issued with those operands.
